// File: rtl/cpu_pkg.sv
// Shared loader definitions: state encoding and stream framing constants.
// Imported by the instruction-memory loader and its word assembler.
package cpu_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } ld_state_e;

  function automatic logic st_accepts(input ld_state_e s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA);
  endfunction

  function automatic logic st_can_start(input ld_state_e s);
    return (s == S_IDLE) || (s == S_DONE) || (s == S_ERROR);
  endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects stream bytes little-endian into a 32-bit word.
// word_full flags the byte that completes the word; word_next includes it.
module word_assembler
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [7:0]            byte_i,
  output logic [DATA_WIDTH-1:0] word_next_o,
  output logic                  word_full_o
);

  logic [BCNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  always_comb begin
    word_next_o = word_q;
    word_next_o[{cnt_q, 3'b000} +: 8] = byte_i;
  end

  assign word_full_o = load_i && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (load_i) begin
      cnt_d  = cnt_q + 1'b1;
      word_d = word_next_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: 16-bit word-count header then little-endian words,
// one instruction RAM write per word; holds the CPU until a clean load.
module imem_loader
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_MEM_CELLS = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               byte_in,
  input  logic                     byte_valid,
  output logic                     byte_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]    wr_data,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error
);

  localparam int IDX_W = $clog2(NUM_MEM_CELLS) + 1;

  ld_state_e             state_q, state_d;
  logic [15:0]           len_q;
  logic [15:0]           len_full;
  logic [IDX_W-1:0]      word_idx_q;
  logic [IDX_W-1:0]      idx_inc;
  logic                  rdy_q;
  logic                  wr_en_q;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  hold_q;
  logic                  done_q;
  logic                  err_q;
  logic                  xfer;
  logic                  start_acc;
  logic                  asm_load;
  logic                  word_full;
  logic                  last_word;
  logic [DATA_WIDTH-1:0] word_next;

  assign xfer      = byte_valid && rdy_q;
  assign start_acc = start && st_can_start(state_q);
  assign asm_load  = xfer && (state_q == S_DATA);
  assign len_full  = {byte_in, len_q[7:0]};
  assign idx_inc   = word_idx_q + 1'b1;
  assign last_word = (16'(idx_inc) == len_q);

  word_assembler #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_asm (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (start_acc),
    .load_i      (asm_load),
    .byte_i      (byte_in),
    .word_next_o (word_next),
    .word_full_o (word_full)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERROR:
        if (start) state_d = S_LEN_LO;
      S_LEN_LO:
        if (xfer) state_d = S_LEN_HI;
      S_LEN_HI:
        if (xfer) begin
          if (len_full == 16'd0)
            state_d = S_DONE;
          else if (len_full > 16'(NUM_MEM_CELLS))
            state_d = S_ERROR;
          else
            state_d = S_DATA;
        end
      S_DATA:
        if (word_full) state_d = S_WRITE;
      S_WRITE:
        state_d = last_word ? S_DONE : S_DATA;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they track state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      rdy_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= st_accepts(state_d);
      hold_q  <= (state_d != S_DONE);
      done_q  <= (state_d == S_DONE);
      err_q   <= (state_d == S_ERROR);
      wr_en_q <= (state_d == S_WRITE);
      if (start_acc) begin
        word_idx_q <= '0;
        len_q      <= '0;
      end
      if (xfer && state_q == S_LEN_LO)
        len_q[7:0] <= byte_in;
      if (xfer && state_q == S_LEN_HI)
        len_q[15:8] <= byte_in;
      if (word_full) begin
        wr_addr_q <= ADDRESS_WIDTH'({word_idx_q, 2'b00});
        wr_data_q <= word_next;
      end
      if (state_q == S_WRITE)
        word_idx_q <= idx_inc;
    end
  end

  assign byte_ready = rdy_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule
